// File: rtl/outport_arbiter_pkg.sv
// Shared router package for the output-port arbiter slice.
// Holds the requester count, flit width, requester index names, the VC
// encoding and the rotate-pointer advance helper.
package outport_arbiter_pkg;

    localparam int NREQ  = 3;
    localparam int DW    = 64;
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Requester indices into req/din/gnt.
    typedef enum logic [PTR_W-1:0] {
        REQ_CW  = 2'd0,
        REQ_CCW = 2'd1,
        REQ_PE  = 2'd2
    } req_idx_e;

    // Virtual-channel encoding; also the polarity value that makes a VC internal.
    typedef enum logic {
        VC0 = 1'b0,
        VC1 = 1'b1
    } vc_e;

    // Pointer value after granting requester idx: the one just past it, wrapping.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        if (int'(idx) == NREQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/outport_arbiter_if.sv
// Bundle between one output-port arbiter, its requesting input channels and
// its two VC buffer cells.
//   polarity            router polarity bit (selects the internal VC)
//   req_vc0/req_vc1     per-requester requests for each VC
//   din                 requester flits, requester i at [i*DW +: DW]
//   full_vc0/full_vc1   VC cell full flags
//   gnt                 one-hot grant back to the requesters
//   enq_vc0/enq_vc1     enqueue strobes to the VC cells
//   d_out               flit presented to both cells
//   phase_*             internal/external phase pins of both cells
// modport master: the arbiter side; modport slave: requesters + cells.
interface outport_arbiter_if;
    import outport_arbiter_pkg::*;

    logic                 polarity;
    logic [NREQ-1:0]      req_vc0;
    logic [NREQ-1:0]      req_vc1;
    logic [NREQ*DW-1:0]   din;
    logic                 full_vc0;
    logic                 full_vc1;
    logic [NREQ-1:0]      gnt;
    logic                 enq_vc0;
    logic                 enq_vc1;
    logic [DW-1:0]        d_out;
    logic                 phase_int_vc0;
    logic                 phase_int_vc1;
    logic                 phase_ext_vc0;
    logic                 phase_ext_vc1;

    modport master (
        input  polarity, req_vc0, req_vc1, din, full_vc0, full_vc1,
        output gnt, enq_vc0, enq_vc1, d_out,
               phase_int_vc0, phase_int_vc1, phase_ext_vc0, phase_ext_vc1
    );

    modport slave (
        output polarity, req_vc0, req_vc1, din, full_vc0, full_vc1,
        input  gnt, enq_vc0, enq_vc1, d_out,
               phase_int_vc0, phase_int_vc1, phase_ext_vc0, phase_ext_vc1
    );

endinterface

// File: rtl/outport_arbiter_rr_pick.sv
// Combinational rotate-priority picker.
//   req  N-wide request vector
//   ptr  index with highest priority this cycle
//   gnt  one-hot grant to the first request at or after ptr (wrapping)
//   any  1 when some request was granted
module outport_arbiter_rr_pick
    import outport_arbiter_pkg::*;
#(
    parameter int N  = NREQ,
    parameter int PW = PTR_W
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);

    logic [PW-1:0] sel;

    // Scan N positions starting at ptr; the first hit wins and masks the rest.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        sel = '0;
        for (int k = 0; k < N; k++) begin
            sel = PW'((int'(ptr) + k) % N);
            if (!any && req[sel]) begin
                gnt[sel] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/outport_arbiter.sv
// Per-output-port round-robin arbiter/sequencer for the two-VC output cells.
// Each cycle the VC selected by polarity (the internal VC) may accept one
// flit: the first eligible requester at or after that VC's pointer is
// granted, its flit is driven on d_out and the VC's enqueue is raised.
// The phase pins of both cells are decoded straight from polarity.
//   clk, reset  clock and synchronous active-high reset
//   bus         arbiter side of outport_arbiter_if (see interface header)
module outport_arbiter
    import outport_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    outport_arbiter_if.master   bus
);

    vc_e              act_vc;
    logic [NREQ-1:0]  req_act;
    logic             full_act;
    logic [NREQ-1:0]  elig;
    logic [PTR_W-1:0] ptr0;
    logic [PTR_W-1:0] ptr1;
    logic [PTR_W-1:0] ptr_act;
    logic [NREQ-1:0]  pick_gnt;
    logic             pick_any;
    logic             grant_vld;
    logic [PTR_W-1:0] gnt_idx;
    logic [DW-1:0]    d_sel;

    // Only the internal VC arbitrates; the other VC's requests are ignored.
    assign act_vc   = vc_e'(bus.polarity);
    assign req_act  = (act_vc == VC1) ? bus.req_vc1 : bus.req_vc0;
    assign full_act = (act_vc == VC1) ? bus.full_vc1 : bus.full_vc0;
    assign ptr_act  = (act_vc == VC1) ? ptr1 : ptr0;
    assign elig     = req_act & {NREQ{~full_act}};

    outport_arbiter_rr_pick #(
        .N  (NREQ),
        .PW (PTR_W)
    ) u_pick (
        .req (elig),
        .ptr (ptr_act),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    // Reset blocks the grant combinationally so a held enq is never captured.
    assign grant_vld   = pick_any & ~reset;
    assign bus.gnt     = reset ? '0 : pick_gnt;
    assign bus.enq_vc0 = grant_vld & (act_vc == VC0);
    assign bus.enq_vc1 = grant_vld & (act_vc == VC1);

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
    end

    // AND-OR mux keyed on the masked grant, so d_out is zero without a grant.
    always_comb begin
        d_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i]) begin
                d_sel = bus.din[i*DW +: DW];
            end
        end
    end

    assign bus.d_out = d_sel;

    // Phase pins follow polarity regardless of reset.
    assign bus.phase_int_vc0 = ~bus.polarity;
    assign bus.phase_ext_vc0 =  bus.polarity;
    assign bus.phase_int_vc1 =  bus.polarity;
    assign bus.phase_ext_vc1 = ~bus.polarity;

    // Only the active VC's pointer advances, and only on an actual grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr0 <= '0;
            ptr1 <= '0;
        end else if (pick_any) begin
            if (act_vc == VC1) begin
                ptr1 <= next_ptr(gnt_idx);
            end else begin
                ptr0 <= next_ptr(gnt_idx);
            end
        end
    end

endmodule

// File: tb/tb_outport_arbiter.sv
module tb_outport_arbiter;
    import outport_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    outport_arbiter_if aif();

    outport_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (aif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       pol;
        logic [2:0] r0;
        logic [2:0] r1;
        logic       f0;
        logic       f1;
        logic [2:0] eg;
        logic       e0;
        logic       e1;
    } vec_t;

    vec_t tbl[$];

    // Reference model: per-VC priority order list, most-favoured requester first.
    int order0[$];
    int order1[$];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic p, input logic [2:0] q0,
                         input logic [2:0] q1, input logic fu0, input logic fu1);
        reset        = r;
        aif.polarity = p;
        aif.req_vc0  = q0;
        aif.req_vc1  = q1;
        aif.full_vc0 = fu0;
        aif.full_vc1 = fu1;
        for (int i = 0; i < NREQ*DW/32; i++) aif.din[i*32 +: 32] = $urandom();
    endtask

    task automatic check_outs(input string tag, input logic p, input logic [2:0] eg,
                              input logic e0, input logic e1);
        logic [DW-1:0] exp_d;
        exp_d = '0;
        for (int i = 0; i < NREQ; i++) if (eg[i]) exp_d = aif.din[i*DW +: DW];
        cmp({tag, " gnt"},   64'(aif.gnt), 64'(eg));
        cmp({tag, " enq0"},  64'(aif.enq_vc0), 64'(e0));
        cmp({tag, " enq1"},  64'(aif.enq_vc1), 64'(e1));
        cmp({tag, " d_out"}, aif.d_out, exp_d);
        cmp({tag, " phase"},
            64'({aif.phase_int_vc0, aif.phase_ext_vc0, aif.phase_int_vc1, aif.phase_ext_vc1}),
            p ? 64'(4'b0110) : 64'(4'b1001));
    endtask

    function automatic void reset_order(output int q[$]);
        q = {};
        for (int i = 0; i < NREQ; i++) q.push_back(i);
    endfunction

    function automatic void after_grant(input int g, output int q[$]);
        q = {};
        for (int k = 1; k <= NREQ; k++) q.push_back((g + k) % NREQ);
    endfunction

    initial begin
        // Directed sequence; rows run back to back, so pointer state carries.
        //            rst   pol   r0      r1      f0    f1    gnt     e0    e1
        tbl.push_back('{1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0});
        // polarity toggling
        tbl.push_back('{1'b0, 1'b0, 3'b001, 3'b100, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'b001, 3'b100, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 3'b001, 3'b100, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'b001, 3'b100, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1});
        // full blocks, pointer holds (ptr0 = 1), then grant 1 -> ptr0 = 2
        tbl.push_back('{1'b0, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0});
        // ptr1 -> 2 via grant to 1, then wrap
        tbl.push_back('{1'b0, 1'b1, 3'b000, 3'b010, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 3'b000, 3'b011, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 3'b000, 3'b011, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1});
        // reset with ptr0 = 2
        tbl.push_back('{1'b1, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0});
        // reset phase pins with polarity 1, then ptr1 = 0
        tbl.push_back('{1'b1, 1'b1, 3'b000, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'b000, 3'b111, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1});
        // inactive VC ignored; full on VC1 blocks
        tbl.push_back('{1'b0, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0});

        drive(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].rst, tbl[n].pol, tbl[n].r0, tbl[n].r1, tbl[n].f0, tbl[n].f1);
            @(negedge clk);
            check_outs($sformatf("vec%0d", n), tbl[n].pol, tbl[n].eg, tbl[n].e0, tbl[n].e1);
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the priority-list model.
        drive(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_order(order0);
        reset_order(order1);
        for (int c = 0; c < 400; c++) begin
            logic       r, p, fu0, fu1;
            logic [2:0] q0, q1, eg;
            int         g;
            r   = ($urandom_range(0, 15) == 0);
            p   = 1'($urandom_range(0, 1));
            q0  = 3'($urandom_range(0, 7));
            q1  = 3'($urandom_range(0, 7));
            fu0 = ($urandom_range(0, 3) == 0);
            fu1 = ($urandom_range(0, 3) == 0);
            drive(r, p, q0, q1, fu0, fu1);
            g = -1;
            if (!r) begin
                if (!p && !fu0) begin
                    foreach (order0[k]) if (g < 0 && q0[order0[k]]) g = order0[k];
                end else if (p && !fu1) begin
                    foreach (order1[k]) if (g < 0 && q1[order1[k]]) g = order1[k];
                end
            end
            eg = (g >= 0) ? 3'(1 << g) : 3'b000;
            @(negedge clk);
            check_outs($sformatf("rnd%0d", c), p, eg, (g >= 0) && !p, (g >= 0) && p);
            @(posedge clk);
            #1;
            if (r) begin
                reset_order(order0);
                reset_order(order1);
            end else if (g >= 0) begin
                if (p) after_grant(g, order1);
                else   after_grant(g, order0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/outport_arbiter.md
# outport_arbiter

Per-output-port round-robin arbiter and sequencer for the two-VC output buffer cells of the cardinal router. Each cycle it selects at most one requesting input channel for the VC currently in its internal phase, and drives that VC's buffer cell enqueue and data. It also drives the internal/external phase pins of both VC cells from the router polarity bit. One instance sits in front of each output port (cw, ccw, pe).

## Interface
- NREQ, 3, number of requesting input channels
- DW, 64, flit width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- polarity  in  1  router polarity; 0: VC0 internal / VC1 external, 1: VC1 internal / VC0 external
- req_vc0  in  NREQ  per-requester request for VC0 of this port
- req_vc1  in  NREQ  per-requester request for VC1 of this port
- din  in  NREQ*DW  requester flits, requester i at bits [i*DW +: DW]
- full_vc0  in  1  VC0 buffer cell full
- full_vc1  in  1  VC1 buffer cell full
- gnt  out  NREQ  one-hot grant; requester pops its input buffer on gnt[i]
- enq_vc0  out  1  enqueue to VC0 cell
- enq_vc1  out  1  enqueue to VC1 cell
- d_out  out  DW  flit to both cells (granted requester's din, else 0)
- phase_int_vc0, phase_int_vc1  out  1  internal-phase pins of each cell
- phase_ext_vc0, phase_ext_vc1  out  1  external-phase pins of each cell

## Operation
- Active VC: v = polarity. phase_int_vcv = 1, phase_ext_vcv = 0; the other VC gets the inverse.
- Eligible set: req_vcv & {NREQ{~full_vcv}}. Requests on the inactive VC are ignored.
- Grant: the first eligible requester at or after ptr_v, wrapping at NREQ-1 → 0.
  - gnt is one-hot to that requester.
  - enq_vcv = 1.
  - d_out = din slice of the granted requester.
- No eligible requester: gnt = 0, enq_vc0 = enq_vc1 = 0, d_out = 0.
- Two independent pointers, ptr0 and ptr1, each of width clog2(NREQ).
  - On a grant to i for VC v: ptr_v ← i+1, or 0 if i = NREQ-1.
  - Otherwise ptr_v holds. The inactive VC's pointer always holds.
- While reset = 1:
  - gnt = 0, enq_vc0 = enq_vc1 = 0, d_out = 0, combinationally.
  - The phase pins still follow polarity.
  - At the clock edge: ptr0 ← 0, ptr1 ← 0.
- No bypass is needed. The active-VC cell drains only on its external phase, so full_vcv cannot fall in the same cycle that VC is internal.

## Timing
- Grant, enq and d_out are combinational from req/full/polarity/pointers in the same cycle.
- The cell captures on the next rising edge, giving 1-cycle latency from request to flit held in the cell.
- Pointer update takes effect at the rising edge after the grant.
- A requester holding req continuously is granted at most once per NREQ active cycles of that VC while others also request.
- Reset deasserted at edge k: the first grant is possible in cycle k, with ptr = 0.
- Reset mid-operation: an enq that is asserted-but-blocked in the reset cycle is not captured. The cell resets in the same cycle.

## Structure
- Shared router package:
  - NREQ, DW
  - requester indices (CW = 0, CCW = 1, PE = 2)
  - VC encoding (VC0 = 0, VC1 = 1)
- Sub-module rr_pick: combinational NREQ-wide rotate-priority picker (req, ptr → one-hot gnt, any).
  - Instantiated once, with the active VC's request vector and pointer muxed in by polarity.
- The top holds the two pointer registers, the data mux and the phase-pin decode.

## Test plan
- Reset, then polarity = 0, req_vc0 = 3'b111, full_vc0 = 0, held 6 active cycles.
  - Required: gnt = 001, 010, 100, 001, 010, 100.
  - Required: enq_vc0 = 1 each active cycle, d_out = matching din slice.
- polarity toggling, req_vc0 = 3'b001, req_vc1 = 3'b100, fulls 0.
  - Required: polarity 0 → gnt = 001, enq_vc0 = 1; polarity 1 → gnt = 100, enq_vc1 = 1. Never both enq.
- polarity = 0, full_vc0 = 1, req_vc0 = 3'b010.
  - Required: gnt = 0, enq_vc0 = 0, ptr0 unchanged.
  - After full_vc0 drops: gnt = 010.
- ptr1 = 2 via a prior grant to requester 1, then req_vc1 = 3'b011.
  - Required: wrap gives gnt = 001, then ptr1 = 1 and the next grant is 010.
- Reset asserted in a cycle with req_vc0 = 3'b100 while ptr0 = 2.
  - Required: gnt = 0 in that cycle.
  - After release: with req_vc0 = 3'b101, gnt = 001 (ptr0 = 0).
- Phase pins for polarity = 0/1.
  - Required (int0, ext0, int1, ext1): 1,0,0,1 and 0,1,1,0, including during reset.
